// File: rtl/mtr_pkg.sv
// Shared widths, channel state encoding and magnitude helper for the motor command shaper.
package mtr_pkg;
  localparam int CMD_W = 12;
  localparam int SPD_W = 11;

  typedef enum logic [1:0] {IDLE, TRACK, DECEL, DWELL} chan_st_e;

  // |v| clipped to SPD_W bits; -2048 is the only value that overflows.
  function automatic logic [SPD_W-1:0] sat_mag(input logic signed [CMD_W-1:0] v);
    logic [CMD_W-1:0] a;
    a = v[CMD_W-1] ? CMD_W'(-v) : CMD_W'(v);
    return a[CMD_W-1] ? {SPD_W{1'b1}} : a[SPD_W-1:0];
  endfunction
endpackage

// File: rtl/mtr_slew_chan.sv
// One wheel channel: slew-limited cur, zero-crossing dwell, spd/rev output registers.
// MTR_DEADZONE_COMP_EN adds MIN_DUTY to every nonzero magnitude.
module mtr_slew_chan import mtr_pkg::*; #(
  parameter int               SLEW_STEP = 16,
  parameter int               DWELL_TCK = 2,
  parameter logic [SPD_W-1:0] MIN_DUTY  = 11'h0A0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic signed [CMD_W-1:0] tgt,
  output logic [SPD_W-1:0]        spd,
  output logic                    rev,
  output logic                    hit
);
  localparam int DW = (DWELL_TCK > 1) ? $clog2(DWELL_TCK) : 1;

  chan_st_e                st;
  logic signed [CMD_W-1:0] cur, dec;
  logic [DW-1:0]           dcnt;
  logic [SPD_W-1:0]        mag, spd_nxt;
  logic                    same, opp;

  function automatic logic signed [CMD_W-1:0] step_to(input logic signed [CMD_W-1:0] c, g);
    int d;
    d = int'(g) - int'(c);
    if (d > SLEW_STEP)       return c + $signed(CMD_W'(SLEW_STEP));
    else if (d < -SLEW_STEP) return c - $signed(CMD_W'(SLEW_STEP));
    else                     return g;
  endfunction

  assign dec  = step_to(cur, '0);
  assign same = (tgt != '0) && (tgt[CMD_W-1] == cur[CMD_W-1]);
  assign opp  = (tgt != '0) && (tgt[CMD_W-1] != cur[CMD_W-1]);
  assign mag  = sat_mag(cur);
  assign hit  = (cur == tgt) && (st != DWELL);

`ifdef MTR_DEADZONE_COMP_EN
  logic [CMD_W-1:0] sum;
  assign sum     = {1'b0, mag} + {1'b0, MIN_DUTY};
  assign spd_nxt = (mag == '0) ? '0 : (sum[CMD_W-1] ? {SPD_W{1'b1}} : sum[SPD_W-1:0]);
`else
  logic unused_min_duty;
  assign unused_min_duty = ^MIN_DUTY;
  assign spd_nxt         = mag;
`endif

  // Leaving TRACK takes the first decel step on the same tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= IDLE;
      cur  <= '0;
      dcnt <= '0;
      spd  <= '0;
      rev  <= 1'b0;
    end else begin
      spd <= spd_nxt;
      rev <= cur[CMD_W-1];
      if (tick) begin
        case (st)
          IDLE: if (tgt != '0) begin
            st  <= TRACK;
            cur <= step_to(cur, tgt);
          end
          TRACK: if (same) cur <= step_to(cur, tgt);
          else begin
            cur  <= dec;
            dcnt <= '0;
            st   <= (dec != '0) ? DECEL : (opp ? DWELL : IDLE);
          end
          DECEL: begin
            cur  <= dec;
            dcnt <= '0;
            if (dec == '0) st <= opp ? DWELL : IDLE;
          end
          DWELL: if (dcnt == DW'(DWELL_TCK-1)) st <= IDLE;
          else dcnt <= dcnt + 1'b1;
          default: st <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: rtl/mtr_cmd_shaper.sv
// Two-wheel command shaper upstream of mtr_drv: shared tick, target capture and at_tgt.
// MTR_DEADZONE_COMP_EN enables dead-zone offset in the channels.
module mtr_cmd_shaper import mtr_pkg::CMD_W, mtr_pkg::SPD_W; #(
  parameter int          UPD_DIV   = 2048,
  parameter int          SLEW_STEP = 16,
  parameter int          DWELL     = 2,
  parameter logic [10:0] MIN_DUTY  = 11'h0A0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_vld,
  input  logic [CMD_W-1:0] lft_cmd,
  input  logic [CMD_W-1:0] rght_cmd,
  input  logic             en,
  output logic [SPD_W-1:0] lft_spd,
  output logic             lft_rev,
  output logic [SPD_W-1:0] rght_spd,
  output logic             rght_rev,
  output logic             at_tgt
);
  localparam int NUM_CH = 2;
  localparam int CW     = $clog2(UPD_DIV);

  logic [CW-1:0]                   cnt;
  logic                            tick;
  logic [NUM_CH-1:0][CMD_W-1:0]    tgt_q, eff;
  logic [NUM_CH-1:0][SPD_W-1:0]    spd;
  logic [NUM_CH-1:0]               rev, hit;

  assign tick = (cnt == CW'(UPD_DIV-1));
  assign eff  = en ? tgt_q : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      tgt_q  <= '0;
      at_tgt <= 1'b1;
    end else begin
      cnt    <= tick ? '0 : cnt + 1'b1;
      at_tgt <= &hit;
      if (cmd_vld) tgt_q <= {rght_cmd, lft_cmd};
    end
  end

  // Channel 0 is left, channel 1 is right.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mtr_slew_chan #(
      .SLEW_STEP(SLEW_STEP),
      .DWELL_TCK(DWELL),
      .MIN_DUTY (MIN_DUTY)
    ) u_chan (
      .clk (clk),
      .rst (rst),
      .tick(tick),
      .tgt (eff[i]),
      .spd (spd[i]),
      .rev (rev[i]),
      .hit (hit[i])
    );
  end

  assign lft_spd  = spd[0];
  assign lft_rev  = rev[0];
  assign rght_spd = spd[1];
  assign rght_rev = rev[1];
endmodule
